// File: rtl/serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_addsub_ctrl
// Function : bit-serial add/subtract over WIDTH cycles, LSB first, with a
//            ripple carry flip-flop. Optional signed overflow via SERIAL_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout
`ifdef SERIAL_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_cnext;

  assign w_s     = r_a[0] ^ r_b[0] ^ r_c;
  assign w_cnext = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sum    <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
      o_cout   <= 1'b0;
`ifdef SERIAL_OVF_EN
      o_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            r_a     <= i_a;
            r_b     <= i_sub ? ~i_b : i_b;
            r_c     <= i_sub;
            r_cnt   <= '0;
            o_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum <= {w_s, r_sum[WIDTH-1:1]};
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_cnext;
          if (r_cnt == C_LAST) begin
            o_result <= {w_s, r_sum[WIDTH-1:1]};
            o_cout   <= w_cnext;
`ifdef SERIAL_OVF_EN
            // r_c here is the carry into the MSB slice.
            o_ovf    <= r_c ^ w_cnext;
`endif
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          o_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/serial_addsub_ctrl.md
# serial_addsub_ctrl

Bit-serial add/subtract controller that sequences a single full-adder bit slice over `WIDTH` clock cycles, LSB first, to produce a `WIDTH`-bit sum or difference. It latches operands on a start handshake and holds the ripple carry in a flip-flop between bit steps. It reports completion with a one-cycle `done` pulse. It sits between the operand source and the shared one-bit full-adder datapath, and trades latency for area against the parallel adder/subtractor.

## Interface
- `WIDTH`, default 8, operand/result width in bits; legal range ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `sub`  in  1  0 = a+b, 1 = a−b; sampled with `start`.
- `a`  in  WIDTH  operand A; sampled with `start`.
- `b`  in  WIDTH  operand B; sampled with `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; `result`/`cout` valid.
- `result`  out  WIDTH  sum/difference, modulo 2^WIDTH.
- `cout`  out  1  final carry; in subtract mode 1 = no borrow (a ≥ b unsigned).
- `ovf`  out  1  signed overflow; present only with `SERIAL_OVF_EN`.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE:** on `start`=1:
  - latch `a` into shift register A.
  - latch `b` into shift register B, or `~b` when `sub`=1.
  - set carry FF to `sub`.
  - clear bit counter; go to RUN.
- **RUN, one bit per cycle:**
  - s = A[0]^B[0]^c.
  - c_next = (A[0]&B[0]) | (c&(A[0]^B[0])).
  - shift s into the MSB of the internal sum register; shift A and B right by 1.
  - increment counter.
  - On the step where counter = WIDTH−1, copy the full sum to `result`, the carry to `cout`, and go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then go to IDLE unconditionally.
- `start` is ignored in RUN and DONE; there is no queuing.
- `result` and `cout` change only on the transition into DONE, and hold until the next completed operation.
- Operands changing after acceptance have no effect.
- Counter width is clog2(WIDTH). The counter never wraps within an operation.
- Reset value of every output is 0: `busy`, `done`, `result`, `cout`, `ovf`.
- Internal shift registers, carry FF and counter also reset to 0.
- `rst` asserted mid-operation aborts immediately. The FSM returns to IDLE, outputs clear, and no `done` pulse is issued. The first `start` after `rst` deasserts is accepted normally.

## Timing
- `start` is sampled at edge E0. `busy`=1 after E0 through E(WIDTH).
- Bit i is computed on edge E(i+1).
- `done`=1 and `result` valid after edge E(WIDTH), for one cycle. `busy` is 0 in that cycle.
- Latency from start edge to done: WIDTH cycles.
- Minimum start-to-start spacing: WIDTH+2 cycles. A `start` held high during DONE is accepted in the following IDLE cycle.
- No combinational path from inputs to outputs; all outputs are registered.

## Configuration
- `SERIAL_OVF_EN` defined:
  - adds the `ovf` port.
  - the carry into the MSB step is captured; `ovf` = carry_in_MSB ^ final carry.
  - `ovf` is updated with `result`, held until the next completion, and reset to 0.
- `SERIAL_OVF_EN` undefined: `ovf` port and its logic are absent. All other behaviour is identical.

## Test plan
All cases use WIDTH=8.
- **Add:** a=0x5A, b=0x3C, sub=0, start pulse at E0.
  - `busy` high E0–E8.
  - `done` after E8; `result`=0x96, `cout`=0.
- **Subtract, no borrow / with borrow:**
  - a=0x10, b=0x01, sub=1 → `result`=0x0F, `cout`=1.
  - then a=0x00, b=0x01, sub=1 → `result`=0xFF, `cout`=0.
- **Wrap and overflow:**
  - a=0xFF, b=0x01, add → `result`=0x00, `cout`=1, `ovf`=0.
  - a=0x7F, b=0x01, add → `result`=0x80, `cout`=0, `ovf`=1 (macro on).
  - a=0x80, b=0x01, sub → `result`=0x7F, `ovf`=1 (macro on).
- **Start during busy:** start a=0x01, b=0x02.
  - At E3 pulse `start` with a=0xF0, b=0x0F; it is ignored.
  - `done` after E8 with `result`=0x03.
  - Exactly one `done` pulse.
- **Reset mid-op:** start a=0xAA, b=0x55; assert `rst` asynchronously between E4 and E5.
  - `busy`, `done`, `result`, `cout` go to 0 immediately; no `done` follows.
  - After release, a=0x01, b=0x01 add → `result`=0x02 after 8 cycles.
- **Back-to-back:** `start` held high continuously with a=0x03, b=0x04.
  - Operations complete every 10 cycles, each with `result`=0x07.
